// File: rtl/autoc_detect_ctrl_pkg.sv
// Shared definitions for the delay-and-correlate preamble detector controller.
//   state_e       : FSM encoding, also used for the state readback field
//   WarmupDefault : default pipeline-fill length (2x correlator delay)
//   LenWDefault   : default width of plateau/holdoff lengths and counters
//   sat_inc16     : 16-bit saturating increment for the statistics counters
package autoc_detect_ctrl_pkg;

    localparam int unsigned WarmupDefault = 64;
    localparam int unsigned LenWDefault   = 16;

    typedef enum logic [2:0] {
        StIdle    = 3'd0,
        StWarmup  = 3'd1,
        StSearch  = 3'd2,
        StPlateau = 3'd3,
        StHoldoff = 3'd4
    } state_e;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/autoc_mag_cmp.sv
// Magnitude compare for the correlator outputs: mag = |si| + |sq| (CW+1 bits,
// no saturation) compared against an unsigned threshold, result registered.
// Ports:
//   clk, rst_n : clock, async active-low reset
//   i_si, i_sq : correlator outputs, CW-bit two's complement
//   i_thresh   : CW+1-bit unsigned threshold
//   o_mag_ok   : (mag >= thresh), one cycle after si/sq
module autoc_mag_cmp #(
    parameter int unsigned CW = 43
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [CW-1:0] i_si,
    input  logic [CW-1:0] i_sq,
    input  logic [CW:0]   i_thresh,
    output logic          o_mag_ok
);

    logic [CW-1:0] w_abs_i;
    logic [CW-1:0] w_abs_q;
    logic [CW:0]   w_mag;
    logic          r_mag_ok;

    // Negating -2^(CW-1) yields 2^(CW-1), which is exact as an unsigned CW-bit value.
    assign w_abs_i = i_si[CW-1] ? (~i_si + CW'(1)) : i_si;
    assign w_abs_q = i_sq[CW-1] ? (~i_sq + CW'(1)) : i_sq;
    assign w_mag   = {1'b0, w_abs_i} + {1'b0, w_abs_q};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mag_ok <= 1'b0;
        end else begin
            r_mag_ok <= (w_mag >= i_thresh);
        end
    end

    assign o_mag_ok = r_mag_ok;

endmodule

// File: rtl/autoc_detect_ctrl.sv
// Sequencer for the delay-and-correlate preamble detector. Gates the DDC and
// autocorrelator enables, waits out the pipeline fill, and raises a one-cycle
// detect after a run of plateau_len consecutive above-threshold magnitudes.
// Optional build macro: AUTOC_CTRL_STATS_EN enables the det_count/false_starts
// saturating counters; without it both ports are tied to zero.
// Ports:
//   clk, rst_n                   : clock, async active-low reset
//   i_arm, i_abort               : start pulse (IDLE only) / return-to-IDLE pulse
//   i_thresh                     : magnitude threshold (CW+1 bits, unsigned)
//   i_plateau_len, i_holdoff_len : run length to detect (0 acts as 1), dead cycles after detect
//   i_si, i_sq, i_outputting     : correlator outputs and their valid
//   o_autoc_enable, o_ddc_enable : datapath enables (identical timing)
//   o_detect, o_det_time         : detect pulse and timestamp captured with it
//   o_busy, o_state              : state != IDLE, raw state readback
//   o_det_count, o_false_starts  : statistics (zero unless AUTOC_CTRL_STATS_EN)
module autoc_detect_ctrl
    import autoc_detect_ctrl_pkg::*;
#(
    parameter int unsigned CW     = 43,
    parameter int unsigned WARMUP = WarmupDefault,
    parameter int unsigned LEN_W  = LenWDefault
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_arm,
    input  logic             i_abort,
    input  logic [CW:0]      i_thresh,
    input  logic [LEN_W-1:0] i_plateau_len,
    input  logic [LEN_W-1:0] i_holdoff_len,
    input  logic [CW-1:0]    i_si,
    input  logic [CW-1:0]    i_sq,
    input  logic             i_outputting,
    output logic             o_autoc_enable,
    output logic             o_ddc_enable,
    output logic             o_detect,
    output logic [31:0]      o_det_time,
    output logic             o_busy,
    output logic [2:0]       o_state,
    output logic [15:0]      o_det_count,
    output logic [15:0]      o_false_starts
);

    localparam int unsigned WarmW = $clog2(WARMUP + 1);
    localparam logic [WarmW-1:0] WarmMax  = WarmW'(WARMUP);
    localparam logic [WarmW-1:0] WarmLast = WarmW'(WARMUP - 1);

    state_e           r_state;
    logic             r_enable;
    logic             r_detect;
    logic [31:0]      r_det_time;
    logic [31:0]      r_ts;
    logic [WarmW-1:0] r_warm;
    logic [LEN_W-1:0] r_run;
    logic [LEN_W-1:0] r_hold;
    logic             w_mag_ok;
    logic [LEN_W-1:0] w_plen_eff;
    logic [LEN_W-1:0] w_run_next;
`ifdef AUTOC_CTRL_STATS_EN
    logic [15:0]      r_det_count;
    logic [15:0]      r_false_starts;
`endif

    autoc_mag_cmp #(
        .CW(CW)
    ) u_mag_cmp (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_si    (i_si),
        .i_sq    (i_sq),
        .i_thresh(i_thresh),
        .o_mag_ok(w_mag_ok)
    );

    assign w_plen_eff = (i_plateau_len == '0) ? LEN_W'(1) : i_plateau_len;
    // First good sample in SEARCH starts the run at 1, so plateau_len=1 detects straight from SEARCH.
    assign w_run_next = (r_state == StSearch) ? LEN_W'(1) : r_run + LEN_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ts <= '0;
        end else begin
            r_ts <= r_ts + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= StIdle;
            r_enable   <= 1'b0;
            r_detect   <= 1'b0;
            r_det_time <= '0;
            r_warm     <= '0;
            r_run      <= '0;
            r_hold     <= '0;
`ifdef AUTOC_CTRL_STATS_EN
            r_det_count    <= '0;
            r_false_starts <= '0;
`endif
        end else begin
            r_detect <= 1'b0;
            if (i_abort) begin
                // Abort wins over arm and over a detect due this cycle.
                r_state  <= StIdle;
                r_enable <= 1'b0;
            end else begin
                unique case (r_state)
                    StIdle: begin
                        if (i_arm) begin
                            r_state  <= StWarmup;
                            r_enable <= 1'b1;
                            r_warm   <= '0;
                            r_run    <= '0;
                            r_hold   <= '0;
`ifdef AUTOC_CTRL_STATS_EN
                            r_det_count    <= '0;
                            r_false_starts <= '0;
`endif
                        end
                    end
                    StWarmup: begin
                        if (r_warm != WarmMax) begin
                            r_warm <= r_warm + WarmW'(1);
                        end
                        // r_warm counts completed cycles; this cycle is the WARMUP-th enabled one.
                        if ((r_warm >= WarmLast) && i_outputting) begin
                            r_state <= StSearch;
                        end
                    end
                    StSearch, StPlateau, StHoldoff: begin
                        if (!i_outputting) begin
                            r_state <= StWarmup;
                            r_warm  <= '0;
                            r_run   <= '0;
                        end else if (r_state == StHoldoff) begin
                            if (r_hold >= i_holdoff_len) begin
                                r_state <= StSearch;
                            end else begin
                                r_hold <= r_hold + LEN_W'(1);
                            end
                        end else if (w_mag_ok) begin
                            if (w_run_next >= w_plen_eff) begin
                                r_detect   <= 1'b1;
                                // Latch the value the timestamp shows while detect is high.
                                r_det_time <= r_ts + 32'd1;
                                r_state    <= StHoldoff;
                                r_hold     <= '0;
                                r_run      <= '0;
`ifdef AUTOC_CTRL_STATS_EN
                                r_det_count <= sat_inc16(r_det_count);
`endif
                            end else begin
                                r_state <= StPlateau;
                                r_run   <= w_run_next;
                            end
                        end else if (r_state == StPlateau) begin
                            r_state <= StSearch;
                            r_run   <= '0;
`ifdef AUTOC_CTRL_STATS_EN
                            r_false_starts <= sat_inc16(r_false_starts);
`endif
                        end
                    end
                    default: begin
                        r_state  <= StIdle;
                        r_enable <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign o_autoc_enable = r_enable;
    assign o_ddc_enable   = r_enable;
    assign o_detect       = r_detect;
    assign o_det_time     = r_det_time;
    assign o_busy         = (r_state != StIdle);
    assign o_state        = r_state;

`ifdef AUTOC_CTRL_STATS_EN
    assign o_det_count    = r_det_count;
    assign o_false_starts = r_false_starts;
`else
    assign o_det_count    = '0;
    assign o_false_starts = '0;
`endif

endmodule

// File: tb/tb_autoc_detect_ctrl.sv
// Bench for autoc_detect_ctrl: expected detect cycles/timestamps are queued when the
// magnitude stimulus is driven and popped by a monitor when the DUT pulses detect.
module tb_autoc_detect_ctrl;

    localparam int unsigned CW    = 43;
    localparam int unsigned LEN_W = 16;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             arm, abort, outputting;
    logic [CW:0]      thresh;
    logic [LEN_W-1:0] plen, hlen;
    logic [CW-1:0]    si, sq;
    logic             autoc_en, ddc_en, detect, busy;
    logic [31:0]      det_time;
    logic [2:0]       state;
    logic [15:0]      det_count, false_starts;

    autoc_detect_ctrl dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_arm         (arm),
        .i_abort       (abort),
        .i_thresh      (thresh),
        .i_plateau_len (plen),
        .i_holdoff_len (hlen),
        .i_si          (si),
        .i_sq          (sq),
        .i_outputting  (outputting),
        .o_autoc_enable(autoc_en),
        .o_ddc_enable  (ddc_en),
        .o_detect      (detect),
        .o_det_time    (det_time),
        .o_busy        (busy),
        .o_state       (state),
        .o_det_count   (det_count),
        .o_false_starts(false_starts)
    );

    always #5 clk = ~clk;

    // Reference cycle count: timestamp value expected in the current cycle.
    int unsigned cyc;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;
    int unsigned exp_q[$];
    int unsigned last_det = 0;
    int unsigned mon_e;
    int unsigned c;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_abort();
        abort = 1'b1;
        tick(1);
        abort = 1'b0;
    endtask

    task automatic go_search();
        int n;
        arm = 1'b1;
        tick(1);
        arm = 1'b0;
        n = 0;
        while (state != 3'd2 && n < 200) begin
            tick(1);
            n++;
        end
        if (n >= 200) check_eq("search_timeout", 64'(state), 64'd2);
    endtask

    task automatic set_mag_high();
        si = CW'(600);
        sq = -(CW'(500));
    endtask

    task automatic set_mag_zero();
        si = '0;
        sq = '0;
    endtask

    task automatic check_stats(input string tag, input int unsigned det, input int unsigned fs);
        int unsigned ed, ef;
        ed = det;
        ef = fs;
`ifndef AUTOC_CTRL_STATS_EN
        ed = 0;
        ef = 0;
`endif
        check_eq({tag, "_det_count"}, 64'(det_count), 64'(ed));
        check_eq({tag, "_false_starts"}, 64'(false_starts), 64'(ef));
    endtask

    // Scoreboard monitor: every detect must match the oldest queued expectation.
    always @(negedge clk) begin
        if (rst_n && detect) begin
            if (exp_q.size() == 0) begin
                check_eq("det_unexpected", 64'(detect), 64'd0);
            end else begin
                mon_e = exp_q.pop_front();
                check_eq("det_cycle", 64'(cyc), 64'(mon_e));
                check_eq("det_time", 64'(det_time), 64'(mon_e));
                last_det = mon_e;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        arm = 1'b0; abort = 1'b0; outputting = 1'b0;
        thresh = (CW+1)'(1000); plen = 16'd4; hlen = 16'd0;
        set_mag_zero();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_eq("rst_state", 64'(state), 64'd0);
        check_eq("rst_autoc_en", 64'(autoc_en), 64'd0);
        check_eq("rst_ddc_en", 64'(ddc_en), 64'd0);
        check_eq("rst_detect", 64'(detect), 64'd0);
        check_eq("rst_det_time", 64'(det_time), 64'd0);
        check_eq("rst_busy", 64'(busy), 64'd0);
        check_stats("rst", 0, 0);

        // Warm-up length: SEARCH exactly 64 cycles after the enables rise.
        tick(1);
        c = cyc;
        arm = 1'b1;
        tick(1);
        arm = 1'b0;
        check_eq("warm_state", 64'(state), 64'd1);
        check_eq("warm_autoc_en", 64'(autoc_en), 64'd1);
        check_eq("warm_ddc_en", 64'(ddc_en), 64'd1);
        check_eq("warm_busy", 64'(busy), 64'd1);
        tick(9);
        outputting = 1'b1;
        tick(54);
        check_eq("warm_last", 64'(state), 64'd1);
        tick(1);
        check_eq("search_entry", 64'(state), 64'd2);

        // plateau_len=4, mag=1100 >= 1000: detect 5 cycles after the data.
        c = cyc;
        set_mag_high();
        exp_q.push_back(c + 5);
        tick(4);
        set_mag_zero();
        tick(1);
        check_eq("det_pulse", 64'(detect), 64'd1);
        check_eq("hold_state", 64'(state), 64'd4);
        tick(1);
        check_eq("det_one_cycle", 64'(detect), 64'd0);
        check_eq("search_back", 64'(state), 64'd2);
        check_eq("sb_drain_t3", 64'(exp_q.size()), 64'd0);
        check_stats("t3", 1, 0);

        // Three good samples then a bad one: false start, no detect.
        set_mag_high();
        tick(3);
        set_mag_zero();
        tick(1);
        check_eq("plateau_run", 64'(state), 64'd3);
        tick(1);
        check_eq("false_start_exit", 64'(state), 64'd2);
        check_stats("t4", 1, 1);

        // holdoff_len=10 with the signal held: detects 15 cycles apart.
        do_abort();
        hlen = 16'd10;
        go_search();
        c = cyc;
        set_mag_high();
        exp_q.push_back(c + 5);
        exp_q.push_back(c + 20);
        exp_q.push_back(c + 35);
        tick(36);
        set_mag_zero();
        tick(20);
        check_eq("sb_drain_hold10", 64'(exp_q.size()), 64'd0);
        check_stats("t5a", 3, 0);

        // holdoff_len=0, plateau_len=0: detect every 2 cycles.
        do_abort();
        hlen = 16'd0;
        plen = 16'd0;
        go_search();
        c = cyc;
        set_mag_high();
        for (int k = 1; k <= 4; k++) exp_q.push_back(c + 2 * k);
        tick(7);
        set_mag_zero();
        tick(5);
        check_eq("sb_drain_hold0", 64'(exp_q.size()), 64'd0);
        check_stats("t5b", 4, 0);

        // Abort priority.
        do_abort();
        check_eq("abort_idle", 64'(state), 64'd0);
        arm = 1'b1;
        abort = 1'b1;
        tick(1);
        arm = 1'b0;
        abort = 1'b0;
        check_eq("arm_abort_idle", 64'(state), 64'd0);
        check_eq("arm_abort_en", 64'(autoc_en), 64'd0);
        plen = 16'd4;
        go_search();
        set_mag_high();
        tick(4);
        abort = 1'b1;
        tick(1);
        abort = 1'b0;
        set_mag_zero();
        check_eq("abort_no_det", 64'(detect), 64'd0);
        check_eq("abort_det_state", 64'(state), 64'd0);
        check_eq("abort_autoc_en", 64'(autoc_en), 64'd0);
        check_eq("abort_ddc_en", 64'(ddc_en), 64'd0);
        check_eq("abort_no_latch", 64'(det_time), 64'(last_det));

        // Extreme magnitudes: |-2^42|+|-2^42| = 2^43 meets thresh 2^43 exactly.
        thresh = '0;
        thresh[CW] = 1'b1;
        plen = 16'd1;
        go_search();
        c = cyc;
        si = '0;
        si[CW-1] = 1'b1;
        sq = si;
        exp_q.push_back(c + 2);
        tick(1);
        set_mag_zero();
        tick(2);
        check_eq("max_mag_search", 64'(state), 64'd2);
        si[CW-1] = 1'b1;
        tick(1);
        set_mag_zero();
        tick(3);
        check_eq("half_mag_below", 64'(state), 64'd2);
        check_eq("sb_drain_t7", 64'(exp_q.size()), 64'd0);

        // Reset in the middle of a plateau.
        do_abort();
        thresh = (CW+1)'(1000);
        plen = 16'd4;
        go_search();
        set_mag_high();
        tick(2);
        check_eq("pre_reset_plateau", 64'(state), 64'd3);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_eq("mid_rst_state", 64'(state), 64'd0);
        check_eq("mid_rst_autoc_en", 64'(autoc_en), 64'd0);
        check_eq("mid_rst_ddc_en", 64'(ddc_en), 64'd0);
        check_eq("mid_rst_detect", 64'(detect), 64'd0);
        check_eq("mid_rst_busy", 64'(busy), 64'd0);
        check_eq("mid_rst_det_time", 64'(det_time), 64'd0);
        check_stats("mid_rst", 0, 0);
        set_mag_zero();
        @(negedge clk);
        rst_n = 1'b1;
        tick(1);
        arm = 1'b1;
        tick(1);
        arm = 1'b0;
        check_eq("rearm_state", 64'(state), 64'd1);
        check_eq("rearm_en", 64'(autoc_en), 64'd1);
        tick(3);
        check_eq("sb_final", 64'(exp_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
